// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic HILO_SEL_HI = 1'b1;
  localparam logic HILO_SEL_LO = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Per-operation flags captured at start and consumed at fix-up.
  typedef struct packed {
    logic is_div;
    logic neg_mul;
    logic neg_q;
    logic neg_r;
    logic div0;
  } ctl_t;

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide, one bit per step.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   m;
  logic [CW-1:0]      cnt;
  logic               mode_div;
  logic [WIDTH:0]     sum, trial;

  // Multiply: lower half holds the multiplier, product shifts in from the top.
  // Divide: lower half holds the dividend, quotient bits shift in at bit 0.
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, m};
    if (mode_div) begin
      if (trial[WIDTH]) acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
      else              acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      m        <= '0;
      cnt      <= '0;
      mode_div <= 1'b0;
    end else if (load) begin
      acc      <= {{WIDTH{1'b0}}, (is_div ? opa : opb)};
      m        <= is_div ? opb : opa;
      cnt      <= '0;
      mode_div <= is_div;
    end else if (step) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
    end
  end

  assign acc_hi = acc[2*WIDTH-1:WIDTH];
  assign acc_lo = acc[WIDTH-1:0];
  assign last   = (cnt == CW'(WIDTH-1));

endmodule

// File: rtl/muldiv_unit.sv
// MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers; FSM, sign handling and special cases.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done
);
  state_e             state;
  ctl_t               ctl;
  logic [WIDTH-1:0]   hi, lo, a_raw;
  logic [WIDTH-1:0]   abs_a, abs_b, it_hi, it_lo, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic               sgn, a_neg, b_neg, load, step, last;

  assign sgn   = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg = sgn & srca[WIDTH-1];
  assign b_neg = sgn & srcb[WIDTH-1];
  assign abs_a = a_neg ? -srca : srca;
  assign abs_b = b_neg ? -srcb : srcb;

  assign load = (state == IDLE) && start;
  assign step = (state == RUN);

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .is_div (op[1]),
    .opa    (abs_a),
    .opb    (abs_b),
    .acc_hi (it_hi),
    .acc_lo (it_lo),
    .last   (last)
  );

  // 0x80000000 / -1 falls out naturally: |q| = 2^31, negated wraps back to itself.
  assign prod     = {it_hi, it_lo};
  assign prod_fix = ctl.neg_mul ? -prod : prod;
  assign q_fix    = ctl.neg_q ? -it_lo : it_lo;
  assign r_fix    = ctl.neg_r ? -it_hi : it_hi;

  assign rdata = (hilo_sel == HILO_SEL_HI) ? hi : lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ctl   <= '0;
      a_raw <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ctl.is_div  <= op[1];
            ctl.neg_mul <= ~op[1] & (a_neg ^ b_neg);
            ctl.neg_q   <= op[1] & (a_neg ^ b_neg);
            ctl.neg_r   <= op[1] & a_neg;
            ctl.div0    <= op[1] & (srcb == '0);
            a_raw       <= srca;
            busy        <= 1'b1;
            state       <= RUN;
          end else if (hilo_we) begin
            if (hilo_sel == HILO_SEL_HI) hi <= hilo_wdata;
            else                         lo <= hilo_wdata;
          end
        end
        RUN: if (last) state <= FIX;
        FIX: begin
          if (ctl.is_div) begin
            if (ctl.div0) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file: its two source operands are that block's two read-data outputs. It executes MIPS MULT/MULTU/DIV/DIVU and supports MTHI/MTLO writes and MFHI/MFLO reads. It is multi-cycle, so the control path stalls on busy.

Parameters:
WIDTH, 32, operand width and HI/LO width; iteration count equals WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin operation selected by op; sampled only when idle
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srca  input  WIDTH  operand A (rs); multiplicand or dividend
srcb  input  WIDTH  operand B (rt); multiplier or divisor
hilo_we  input  1  MTHI/MTLO write enable
hilo_sel  input  1  1 = HI, 0 = LO; applies to both write and read
hilo_wdata  input  WIDTH  MTHI/MTLO data
rdata  output  WIDTH  combinational MFHI/MFLO read: hilo_sel ? HI : LO
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when HI/LO are updated by an operation

Behaviour:
- Reset (async, rst_n=0): HI=0, LO=0, state IDLE, busy=0, done=0, counter=0; all internal datapath registers=0. This takes effect immediately, including mid-operation; the in-flight result is discarded.
- States:
  - IDLE: on an edge with start=1, latch op, |srca|, |srcb| (absolute value for signed ops, raw for unsigned) and result-sign flags; counter=0; go to RUN.
  - RUN: one radix-2 iteration per edge. Multiply is shift-add into a 2*WIDTH accumulator. Divide is restoring, 1 quotient bit per edge. After WIDTH iterations (counter==WIDTH-1), go to FIX.
  - FIX: apply sign fix-up, write HI/LO, go to IDLE.
- Timing: start sampled at edge E0. Iterations occur on E1..E32. HI/LO are written on E33. busy=1 from after E0 until after E33. done=1 for exactly the cycle following E33. Next start is accepted at E33+1.
- rdata shows the old HI/LO throughout busy. The new values are visible immediately after E33.
- Multiply result: {HI,LO} = 64-bit product. MULT negates the product when the operand signs differ.
- Divide result: LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divisor 0 (DIV or DIVU): HI=srca (as latched), LO=all ones.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (two's-complement wrap, no trap).
- hilo_we: writes the selected register on the edge, but only when IDLE and start=0. If start and hilo_we are both asserted while idle, start wins and the write is dropped. hilo_we is ignored while busy.
- start while busy: ignored; no queueing; latched operands are unaffected.
- Operands must be stable only at E0; later changes on srca/srcb have no effect.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
  - state enum IDLE/RUN/FIX
  - HILO_SEL_HI/HILO_SEL_LO constants
- One sub-module, muldiv_iter: unsigned shift-add/restoring-divide datapath. It holds the accumulator and counter and takes load/step controls.
- The top level owns the FSM, sign handling, special cases and HI/LO.

Test Plan:
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy high 33 cycles; done pulse after E33; HI=0xFFFFFFFE, LO=0x00000001.
2. MULT 0xFFFFFFFD (-3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIVU 100/7 -> LO=14, HI=2.
3. DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIVU 5/0 -> HI=5, LO=0xFFFFFFFF. DIV 0xFFFFFFFB/0 -> HI=0xFFFFFFFB, LO=0xFFFFFFFF.
5. Start MULTU 2×3. At cycle 5 assert start (DIVU 9/3) and hilo_we HI=0xAAAA -> both ignored; final HI=0, LO=6. Then idle MTLO 0x1234 -> rdata(sel=0)=0x1234 the next cycle.
6. Set HI/LO to 0x11/0x22, start DIVU, pull rst_n low at cycle 10 -> busy=0, done=0, HI=LO=0 immediately. After release, MULTU 4×5 -> LO=20 with no stale state.
